// File: rtl/upload_frame_packer.sv
// Frames one response payload as AA 44 cmd len_hi len_lo payload csum
// and streams it byte-by-byte toward the USB CDC upload path.
module upload_frame_packer #(
    parameter int         MAX_LEN = 256,
    parameter logic [7:0] HDR0    = 8'hAA,
    parameter logic [7:0] HDR1    = 8'h44
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] src_cmd,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    input  logic       src_last,
    output logic       src_ready,
    output logic [7:0] upload_data,
    output logic       upload_valid,
    input  logic       upload_ready,
    output logic       busy,
    output logic       trunc_err
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = AW + 1;

    typedef enum logic [3:0] {
        IDLE, COLLECT, H0, H1, CMD, LENH, LENL, PAY, CSUM
    } state_t;

    state_t        state;
    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    rd_data;
    logic [7:0]    cmd_q;
    logic [7:0]    csum;
    logic [CW-1:0] count;
    logic [CW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [15:0]   len16;
    logic          src_xfer;
    logic          up_xfer;
    logic          rd_adv;

    assign len16    = 16'(count);
    assign src_xfer = src_valid & src_ready;
    assign up_xfer  = upload_valid & upload_ready;
    assign rd_adv   = up_xfer && (state == LENL || state == PAY);
    // rd_data always holds buf[rd_ptr]; step the address as a byte leaves
    assign rd_addr  = rd_adv ? rd_ptr[AW-1:0] + 1'b1 : rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (src_xfer)
            mem[count[AW-1:0]] <= src_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            src_ready    <= 1'b0;
            upload_valid <= 1'b0;
            upload_data  <= 8'h00;
            busy         <= 1'b0;
            trunc_err    <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            csum         <= 8'h00;
            cmd_q        <= 8'h00;
        end else begin
            trunc_err <= 1'b0;
            if (rd_adv)
                rd_ptr <= rd_ptr + 1'b1;
            if (up_xfer && state inside {CMD, LENH, LENL, PAY})
                csum <= csum + upload_data;
            unique case (state)
                IDLE: begin
                    if (src_xfer) begin
                        cmd_q <= src_cmd;
                        count <= CW'(1);
                        busy  <= 1'b1;
                        if (src_last) begin
                            state        <= H0;
                            src_ready    <= 1'b0;
                            upload_valid <= 1'b1;
                            upload_data  <= HDR0;
                        end else begin
                            state <= COLLECT;
                        end
                    end else begin
                        src_ready <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (src_xfer) begin
                        count <= count + 1'b1;
                        if (src_last || count == CW'(MAX_LEN - 1)) begin
                            trunc_err    <= ~src_last;
                            state        <= H0;
                            src_ready    <= 1'b0;
                            upload_valid <= 1'b1;
                            upload_data  <= HDR0;
                        end
                    end
                end
                H0: if (up_xfer) begin
                    upload_data <= HDR1;
                    state       <= H1;
                end
                H1: if (up_xfer) begin
                    upload_data <= cmd_q;
                    state       <= CMD;
                end
                CMD: if (up_xfer) begin
                    upload_data <= len16[15:8];
                    state       <= LENH;
                end
                LENH: if (up_xfer) begin
                    upload_data <= len16[7:0];
                    state       <= LENL;
                end
                LENL: if (up_xfer) begin
                    upload_data <= rd_data;
                    state       <= PAY;
                end
                PAY: if (up_xfer) begin
                    if (rd_ptr == count) begin
                        upload_data <= csum + upload_data;
                        state       <= CSUM;
                    end else begin
                        upload_data <= rd_data;
                    end
                end
                CSUM: if (up_xfer) begin
                    upload_valid <= 1'b0;
                    src_ready    <= 1'b1;
                    busy         <= 1'b0;
                    count        <= '0;
                    rd_ptr       <= '0;
                    csum         <= 8'h00;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
